// File: rtl/kugelblitz_pkg.sv
// Shared types and helpers for the Kugelblitz byte-rewrite stage.
package kugelblitz_pkg;

    // Upper bounds the parametrised blocks are sized against.
    localparam int MAX_RULE_COUNT   = 16;
    localparam int MAX_OFFSET_WIDTH = 16;

    // One rewrite rule; offsets narrower than MAX_OFFSET_WIDTH are zero-extended.
    typedef struct packed {
        logic                        enable;
        logic [MAX_OFFSET_WIDTH-1:0] offset;
        logic [7:0]                  value;
        logic [7:0]                  mask;
    } rule_t;

    // Beat index that holds a frame byte offset.
    function automatic logic [MAX_OFFSET_WIDTH-1:0] offset_beat(
        input logic [MAX_OFFSET_WIDTH-1:0] offset,
        input int                          lane_bits
    );
        return offset >> lane_bits;
    endfunction

    // Byte lane within its beat that holds a frame byte offset.
    function automatic logic [MAX_OFFSET_WIDTH-1:0] offset_lane(
        input logic [MAX_OFFSET_WIDTH-1:0] offset,
        input int                          lane_bits
    );
        return offset & ((MAX_OFFSET_WIDTH'(1) << lane_bits) - MAX_OFFSET_WIDTH'(1));
    endfunction

endpackage

// File: rtl/kugelblitz_rule_bank.sv
// Double-buffered rule storage: shadow rules take config writes, the active
// set is replaced wholesale when a pending commit meets a frame boundary.
module kugelblitz_rule_bank
    import kugelblitz_pkg::*;
#(
    parameter int RULE_COUNT   = 4,
    parameter int OFFSET_WIDTH = 11,
    parameter int RULE_IDX_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr_en,
    input  logic [RULE_IDX_W-1:0]   cfg_rule,
    input  logic                    cfg_enable,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic [7:0]              cfg_value,
    input  logic [7:0]              cfg_mask,
    input  logic                    cfg_commit,
    input  logic                    commit_ok,
    output logic                    cfg_pending,
    output rule_t                   active_rules [RULE_COUNT]
);

    rule_t shadow_rules [RULE_COUNT];
    rule_t shadow_next  [RULE_COUNT];
    logic  apply;

    // A commit only lands on an edge the top reports as a frame boundary.
    assign apply = cfg_pending && commit_ok;

    // Shadow set including this cycle's write, so a same-edge commit picks it up.
    always_comb begin
        // NOTE: full default assignment first so no path leaves shadow_next unassigned (no latch).
        shadow_next = shadow_rules;
        if (cfg_wr_en && (int'(cfg_rule) < RULE_COUNT)) begin
            shadow_next[cfg_rule] = '{
                enable: cfg_enable,
                offset: MAX_OFFSET_WIDTH'(cfg_offset),
                value:  cfg_value,
                mask:   cfg_mask
            };
        end
    end

    // Shadow and active rule registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these arrays are small flop banks, not RAM, so resetting them is cheap and required: every rule must come up disabled.
            for (int i = 0; i < RULE_COUNT; i++) begin
                shadow_rules[i] <= '0;
                active_rules[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge, independent of statement order.
            shadow_rules <= shadow_next;
            if (apply) begin
                active_rules <= shadow_next;
            end
        end
    end

    // Pending flag: set by a commit pulse, cleared on the edge the copy happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pending <= 1'b0;
        end else if (apply) begin
            cfg_pending <= 1'b0;
        end else if (cfg_commit) begin
            cfg_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/kugelblitz_rewrite.sv
// Registered AXI-stream byte-rewrite stage: overwrites masked bits at
// configured frame byte offsets and counts frames that were modified.
module kugelblitz_rewrite
    import kugelblitz_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1,
    parameter int RULE_COUNT   = 4,
    parameter int OFFSET_WIDTH = 11,
    localparam int RULE_IDX_W  = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,

    input  logic                    cfg_wr_en,
    input  logic [RULE_IDX_W-1:0]   cfg_rule,
    input  logic                    cfg_enable,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic [7:0]              cfg_value,
    input  logic [7:0]              cfg_mask,
    input  logic                    cfg_commit,
    output logic                    cfg_pending,

    input  logic                    stat_clear,
    output logic [31:0]             stat_frame_hits
);

    localparam int LANE_BITS = $clog2(KEEP_WIDTH);
    // One bit wider than the largest addressable beat: the saturated count can
    // never equal a rule's beat, so long frames never match past the offset range.
    localparam int BEAT_W = ((OFFSET_WIDTH > LANE_BITS) ? (OFFSET_WIDTH - LANE_BITS) : 0) + 1;

    logic [BEAT_W-1:0]     beat_cnt;
    logic                  frame_hit;
    logic                  s_accept;
    logic                  commit_ok;
    logic                  beat_hit;
    logic [DATA_WIDTH-1:0] rewrite_data;

    rule_t                 active_rules  [RULE_COUNT];
    logic [RULE_COUNT-1:0] rule_on_beat;
    logic [LANE_BITS-1:0]  rule_lane     [RULE_COUNT];

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    // Boundary for swapping rule sets: idle between frames, or the last beat going in.
    assign commit_ok = ((beat_cnt == '0) && !s_accept) || (s_accept && s_axis_tlast);

    kugelblitz_rule_bank #(
        .RULE_COUNT   (RULE_COUNT),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .RULE_IDX_W   (RULE_IDX_W)
    ) u_rule_bank (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_rule     (cfg_rule),
        .cfg_enable   (cfg_enable),
        .cfg_offset   (cfg_offset),
        .cfg_value    (cfg_value),
        .cfg_mask     (cfg_mask),
        .cfg_commit   (cfg_commit),
        .commit_ok    (commit_ok),
        .cfg_pending  (cfg_pending),
        .active_rules (active_rules)
    );

    // Decode each active rule into "targets this beat" and its byte lane.
    always_comb begin
        rule_on_beat = '0;
        for (int i = 0; i < RULE_COUNT; i++) begin
            rule_lane[i]    = LANE_BITS'(offset_lane(active_rules[i].offset, LANE_BITS));
            rule_on_beat[i] = active_rules[i].enable &&
                              (beat_cnt == BEAT_W'(offset_beat(active_rules[i].offset, LANE_BITS)));
        end
    end

    // Apply rules lane by lane in ascending index order, then blank unkept lanes.
    always_comb begin
        rewrite_data = s_axis_tdata;
        beat_hit     = 1'b0;
        for (int j = 0; j < KEEP_WIDTH; j++) begin
            for (int i = 0; i < RULE_COUNT; i++) begin
                if (rule_on_beat[i] && (rule_lane[i] == LANE_BITS'(j)) && s_axis_tkeep[j]) begin
                    rewrite_data[j*8 +: 8] = (rewrite_data[j*8 +: 8] & ~active_rules[i].mask) |
                                             (active_rules[i].value & active_rules[i].mask);
                    beat_hit = 1'b1;
                end
            end
            if (!s_axis_tkeep[j]) begin
                rewrite_data[j*8 +: 8] = 8'h00;
            end
        end
    end

    // Output register: loads on acceptance, holds while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (s_axis_tready) begin
            m_axis_tvalid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                m_axis_tdata <= rewrite_data;
                m_axis_tkeep <= s_axis_tkeep;
                m_axis_tlast <= s_axis_tlast;
                m_axis_tuser <= s_axis_tuser;
            end
        end
    end

    // Beat position within the current frame, saturating on oversized frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (s_accept) begin
            if (s_axis_tlast) begin
                beat_cnt <= '0;
            end else if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end
    end

    // Per-frame hit flag, covering every beat before the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_hit <= 1'b0;
        end else if (s_accept) begin
            frame_hit <= s_axis_tlast ? 1'b0 : (frame_hit || beat_hit);
        end
    end

    // Saturating count of modified frames; a clear beats a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frame_hits <= '0;
        end else if (stat_clear) begin
            stat_frame_hits <= '0;
        end else if (s_accept && s_axis_tlast && (frame_hit || beat_hit) &&
                     (stat_frame_hits != '1)) begin
            stat_frame_hits <= stat_frame_hits + 32'd1;
        end
    end

endmodule

// File: doc/kugelblitz_rewrite.md
# kugelblitz_rewrite

Parametrised, registered AXI-stream byte-rewrite stage for the Kugelblitz offload path, placed inline on one port's TX or RX stream between the MAC side and Corundum. It overwrites masked bits of up to RULE_COUNT configurable byte offsets anywhere in a frame, not just the first beat. A frame-position counter locates each target byte. Rule sets are double-buffered and switch atomically only at frame boundaries. Unlike the current combinational offload, it applies backpressure and counts frames that were modified.

## Interface
Parameters:
- DATA_WIDTH, 512, stream data width; must be a power of two ≥ 64
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 1, tuser width, passed through
- RULE_COUNT, 4, number of rewrite rules (1..16)
- OFFSET_WIDTH, 11, byte-offset width; byte offsets 0..2047

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  stream and config clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  input stream
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  output stream
- cfg_wr_en  in  1  writes the shadow rule selected by cfg_rule
- cfg_rule  in  $clog2(RULE_COUNT) (min 1)  rule index
- cfg_enable  in  1  rule enable
- cfg_offset  in  OFFSET_WIDTH  byte offset from frame start
- cfg_value  in  8  replacement bits
- cfg_mask  in  8  bit mask; 1 = replace
- cfg_commit  in  1  pulse; requests shadow→active copy
- cfg_pending  out  1  commit requested, not yet applied
- stat_clear  in  1  clears stat_frame_hits
- stat_frame_hits  out  32  saturating count of modified frames

## Operation
- Beat position: beat_cnt counts accepted input beats within a frame. It resets to 0 after an accepted tlast beat and saturates at its maximum.
- Byte offset o maps to beat o >> log2(KEEP_WIDTH) and lane o mod KEEP_WIDTH. Offsets beyond the frame end never match.
- A rule fires on an active rule when: enable=1, the beat and lane match, and that lane's tkeep=1.
- Rewrite: out = (in & ~mask) | (value & mask).
- Rules are applied in ascending index order, so the highest index wins on overlapping bits.
- Lanes with tkeep=0 are output as 0x00.
- tkeep, tlast and tuser pass through unchanged.
- Shadow writes: cfg_wr_en updates the shadow copy only and never affects a frame in flight.
- Commit: cfg_commit sets cfg_pending. The commit is applied, copying the full shadow set to the active set, on the first clock edge where either:
  - (a) no frame is in progress and no input beat is accepted, or
  - (b) an input beat with tlast is accepted.
- The copy uses shadow contents as of that edge, so writes made after the commit but before it is applied are included.
- New rules govern the next frame from its first beat. cfg_pending clears on the same edge.
- Statistics: a per-frame hit flag is set if any rule fires on any beat of the frame. When the tlast beat is accepted, stat_frame_hits increments if the flag (including the current beat) is set.
- stat_clear takes priority over a simultaneous increment and yields 0.

## Timing
- Reset values:
  - m_axis_tvalid=0; m_axis data, keep, last and user = 0
  - beat_cnt=0; cfg_pending=0; stat_frame_hits=0
  - all shadow and active rules = 0 (disabled)
- Latency: 1 cycle, from an accepted input beat to m_axis_tvalid.
- Output data comes from a single register stage.
- s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational), which gives full throughput with no bubbles.
- When m_axis_tvalid=1 and m_axis_tready=0, the output holds all fields stable.
- Simultaneous cfg_wr_en and cfg_commit: the write lands in shadow and is included in the commit.
- Second commit while pending: no extra effect.
- A reset mid-frame discards the frame and clears all state, including rules. The next beat is treated as offset 0.

## Structure
- Shared package kugelblitz_pkg holds:
  - rule record typedef (enable, offset, value, mask)
  - RULE_COUNT limit constant
  - helper function for lane/beat decode
- One sub-module, kugelblitz_rule_bank: shadow/active register arrays, commit logic and cfg_pending.
- Datapath, beat counter and stats live in the top module.

## Test plan
- Offset-0 rule: rule 0 = {en=1, off=0, val=0xAA, mask=0xFF}; send a 2-beat frame of 0x11 bytes → output byte 0 = 0xAA, all other bytes 0x11, stat_frame_hits=1.
- Second-beat offset with partial tkeep: rule at off=70, mask=0x0F, val=0x05, input byte 0x3C.
  - With lane 6 of beat 1 valid → output 0x35.
  - With that lane's tkeep=0 → output 0x00 and no count.
- Overlap priority: rule 0 and rule 1 both at off=5, mask=0xFF, values 0x01 and 0x02 → output 0x02.
- Atomic commit: commit pulsed mid-frame on beat 1 of a 4-beat frame.
  - The frame finishes with the old rules.
  - cfg_pending=1 until the tlast acceptance, then 0.
  - The next frame uses the new rules.
- Backpressure: hold m_axis_tready=0 for 5 cycles with a beat pending → output stable, s_axis_tready=0, and no beat lost or duplicated across 100 random frames checked against a reference model.
- Reset and stats: assert rst_n low mid-frame → m_axis_tvalid=0 immediately and counters 0. stat_clear together with a hit-frame tlast → count=0.
